// File: rtl/mips_defs.sv
// rtl/mips_defs.sv - shared MIPS datapath constants for the register file slice
// Purpose: widths, well-known register numbers and the default trace reset PC.
// Ports: none (package).
package mips_defs;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;
  localparam logic [ADDR_W-1:0] REG_RA   = 5'd31;

  localparam logic [DATA_W-1:0] RESET_PC_DEFAULT = 32'h0000_3000;

endpackage

// File: rtl/grf_read_port.sv
// rtl/grf_read_port.sv - one combinational register-file read port with bypass and $0 forcing
// Purpose: selects between zero, the in-flight write data and the stored register value.
// Ports:
//   ra          in  5   read address
//   we, wa, wd  in      write port of the same cycle (for bypass)
//   stored_data in  32  array contents at ra
//   rd          out 32  read data
module grf_read_port
  import mips_defs::*;
#(
  parameter bit BYPASS = 1'b1
) (
  input  logic [ADDR_W-1:0] ra,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic [DATA_W-1:0] stored_data,
  output logic [DATA_W-1:0] rd
);

  always_comb begin
    rd = stored_data;
    if (ra == REG_ZERO) begin
      rd = '0;
    end else if (BYPASS && we && (wa == ra)) begin
      // A write to $0 never reaches here because ra != 0 already.
      rd = wd;
    end
  end

endmodule

// File: rtl/grf_writeback.sv
// rtl/grf_writeback.sv - MIPS general register file and write-back commit stage with trace
// Purpose: 31 writable 32-bit registers ($0 hardwired to zero), two combinational
//          read ports, and a registered one-cycle commit-trace record per write.
// Ports:
//   clk, reset           in      clock; asynchronous active-low reset
//   RA1, RA2             in  5   read addresses (rs, rt)
//   WE, WA, WD           in      write enable / address / data
//   PC                   in  32  PC of the committing instruction (trace only)
//   RD1, RD2             out 32  combinational read data
//   trace_valid/pc/addr/data out registered commit record
module grf_writeback
  import mips_defs::*;
#(
  parameter bit                BYPASS   = 1'b1,
  parameter logic [DATA_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] RA1,
  input  logic [ADDR_W-1:0] RA2,
  input  logic              WE,
  input  logic [ADDR_W-1:0] WA,
  input  logic [DATA_W-1:0] WD,
  input  logic [DATA_W-1:0] PC,
  output logic [DATA_W-1:0] RD1,
  output logic [DATA_W-1:0] RD2,
  output logic              trace_valid,
  output logic [DATA_W-1:0] trace_pc,
  output logic [ADDR_W-1:0] trace_addr,
  output logic [DATA_W-1:0] trace_data
);

  // Entry 0 exists only so every 5-bit address indexes in range; it is never written.
  logic [DATA_W-1:0] regs [32];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= '0;
      end
    end else if (WE && (WA != REG_ZERO)) begin
      regs[WA] <= WD;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      trace_valid <= 1'b0;
      trace_pc    <= RESET_PC;
      trace_addr  <= '0;
      trace_data  <= '0;
    end else begin
      trace_valid <= WE;
      if (WE) begin
        trace_pc   <= PC;
        trace_addr <= WA;
        trace_data <= (WA == REG_ZERO) ? '0 : WD;
      end
    end
  end

  grf_read_port #(.BYPASS(BYPASS)) u_read_port1 (
    .ra          (RA1),
    .we          (WE),
    .wa          (WA),
    .wd          (WD),
    .stored_data (regs[RA1]),
    .rd          (RD1)
  );

  grf_read_port #(.BYPASS(BYPASS)) u_read_port2 (
    .ra          (RA2),
    .we          (WE),
    .wa          (WA),
    .wd          (WD),
    .stored_data (regs[RA2]),
    .rd          (RD2)
  );

endmodule
